// File: rtl/dmem_port_arbiter.sv
// Purpose: shares the single-port dmem between the CPU (priority), a PS2 writer and a VGA reader.
// Latency: grant and mem drive are combinational in the request cycle; rvalid follows 1 cycle later.
// Backpressure: CPU sees cpu_stall and holds; secondaries hold req until their 1-cycle gnt.
//
// Ports:
//   clock, resetn                         clock and asynchronous active-low reset
//   cpu_req/wren/addr/wdata -> cpu_stall  CPU access; cpu_rvalid/cpu_rdata return reads
//   ps2_req/addr/wdata      -> ps2_gnt    PS2 write-only port
//   vga_req/addr            -> vga_gnt    VGA read-only port; vga_rvalid/vga_rdata return
//   mem_addr/wdata/wren, mem_q            dmem syncram interface (1-cycle registered read)
module dmem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ps2_req,
    input  logic [ADDR_W-1:0] ps2_addr,
    input  logic [DATA_W-1:0] ps2_wdata,
    output logic              ps2_gnt,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    // A zero STARVE_MAX still needs a 1-bit counter so the declarations stay legal.
    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    typedef enum logic {
        SEC_PS2 = 1'b0,
        SEC_VGA = 1'b1
    } sec_t;

    logic [CW-1:0] ps2_cnt;
    logic [CW-1:0] vga_cnt;
    sec_t          last_sec;
    logic [1:0]    rd_pipe;   // {cpu read issued, vga read issued}

    logic ps2_starved;
    logic vga_starved;
    logic cpu_g;
    logic ps2_g;
    logic vga_g;

    assign ps2_starved = (STARVE_MAX != 0) && ps2_req && (ps2_cnt == CNT_MAX);
    assign vga_starved = (STARVE_MAX != 0) && vga_req && (vga_cnt == CNT_MAX);

    // Starved secondary beats the CPU; the CPU beats a non-starved secondary;
    // ties between secondaries go to whichever was not granted last.
    // Everything is gated by resetn so nothing is granted while reset is held.
    always_comb begin
        cpu_g = 1'b0;
        ps2_g = 1'b0;
        vga_g = 1'b0;
        if (resetn) begin
            if (ps2_starved && vga_starved) begin
                if (last_sec == SEC_VGA) ps2_g = 1'b1;
                else                     vga_g = 1'b1;
            end else if (ps2_starved) begin
                ps2_g = 1'b1;
            end else if (vga_starved) begin
                vga_g = 1'b1;
            end else if (cpu_req) begin
                cpu_g = 1'b1;
            end else if (ps2_req && vga_req) begin
                if (last_sec == SEC_VGA) ps2_g = 1'b1;
                else                     vga_g = 1'b1;
            end else if (ps2_req) begin
                ps2_g = 1'b1;
            end else if (vga_req) begin
                vga_g = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        if (cpu_g) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wren  = cpu_wren;
        end else if (ps2_g) begin
            mem_addr  = ps2_addr;
            mem_wdata = ps2_wdata;
            mem_wren  = 1'b1;
        end else if (vga_g) begin
            mem_addr  = vga_addr;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ps2_cnt  <= '0;
            vga_cnt  <= '0;
            last_sec <= SEC_VGA;
            rd_pipe  <= 2'b00;
        end else begin
            // Counters only run while a request is actually waiting; they clear on grant or idle.
            if (ps2_g || !ps2_req)       ps2_cnt <= '0;
            else if (ps2_cnt != CNT_MAX) ps2_cnt <= ps2_cnt + CW'(1);

            if (vga_g || !vga_req)       vga_cnt <= '0;
            else if (vga_cnt != CNT_MAX) vga_cnt <= vga_cnt + CW'(1);

            if (ps2_g)      last_sec <= SEC_PS2;
            else if (vga_g) last_sec <= SEC_VGA;

            rd_pipe <= {cpu_g & ~cpu_wren, vga_g};
        end
    end

    assign cpu_stall  = resetn & cpu_req & ~cpu_g;
    assign ps2_gnt    = ps2_g;
    assign vga_gnt    = vga_g;
    assign cpu_rvalid = rd_pipe[1];
    assign vga_rvalid = rd_pipe[0];
    assign cpu_rdata  = mem_q;
    assign vga_rdata  = mem_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose: directed self-checking bench for dmem_port_arbiter with a behavioural dmem.
// Latency: inputs change 1 time unit after the rising edge, outputs are compared 3 units after.
// Backpressure: scenarios hold requests exactly as a well-behaved requester would.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock;
    logic              resetn;
    logic              cpu_req;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ps2_req;
    logic [ADDR_W-1:0] ps2_addr;
    logic [DATA_W-1:0] ps2_wdata;
    logic              ps2_gnt;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    logic [DATA_W-1:0] dmem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .cpu_req    (cpu_req),
        .cpu_wren   (cpu_wren),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ps2_req    (ps2_req),
        .ps2_addr   (ps2_addr),
        .ps2_wdata  (ps2_wdata),
        .ps2_gnt    (ps2_gnt),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port syncram: registered read, read-before-write.
    always @(posedge clock) begin
        if (mem_wren) dmem[mem_addr] <= mem_wdata;
        mem_q <= dmem[mem_addr];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all;
        cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ps2_req = 1'b0; ps2_addr = '0; ps2_wdata = '0;
        vga_req = 1'b0; vga_addr = '0;
    endtask

    task automatic do_reset;
        idle_all();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h005;
        ps2_req = 1'b1; ps2_addr = 12'h006; ps2_wdata = 32'h0000_0066;
        vga_req = 1'b1; vga_addr = 12'h007;
        tick(); tick(); #2;
        checks++;
        if ({ps2_gnt, vga_gnt, cpu_stall, mem_wren, cpu_rvalid, vga_rvalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt/stall/wren/rvalid = %b, expected 000000",
                     {ps2_gnt, vga_gnt, cpu_stall, mem_wren, cpu_rvalid, vga_rvalid});
        end
        checks++;
        if (mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL reset_mem_addr: got %h, expected 000", mem_addr);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if ({cpu_stall, ps2_gnt, vga_gnt} !== 3'b000 || mem_addr !== 12'h005) begin
            errors++;
            $display("FAIL release_cpu_first: stall/ps2/vga = %b addr %h, expected 000 addr 005",
                     {cpu_stall, ps2_gnt, vga_gnt}, mem_addr);
        end
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_cpu_rw;
        do_reset();
        dmem[12'h010] = 32'hDEAD_BEEF;
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h010;
        #2;
        checks++;
        if (mem_addr !== 12'h010 || mem_wren !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_issue: addr %h wren %b stall %b, expected 010 0 0",
                     mem_addr, mem_wren, cpu_stall);
        end
        tick();
        // Write directly behind the read.
        cpu_wren = 1'b1; cpu_addr = 12'h011; cpu_wdata = 32'h1234_5678;
        #2;
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF || vga_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_return: rvalid %b data %h vga_rvalid %b, expected 1 deadbeef 0",
                     cpu_rvalid, cpu_rdata, vga_rvalid);
        end
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 12'h011 || mem_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL cpu_write_issue: wren %b addr %h data %h, expected 1 011 12345678",
                     mem_wren, mem_addr, mem_wdata);
        end
        tick();
        cpu_wren = 1'b0; cpu_addr = 12'h011;
        #2;
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_no_rvalid_after_write: got %b, expected 0", cpu_rvalid);
        end
        tick();
        idle_all();
        #2;
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL cpu_readback: rvalid %b data %h, expected 1 12345678", cpu_rvalid, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_round_robin;
        logic exp_ps2;
        logic exp_rv;
        do_reset();
        dmem[12'h030] = 32'hCAFE_F00D;
        dmem[12'h020] = 32'h0;
        ps2_req = 1'b1; ps2_addr = 12'h020; ps2_wdata = 32'h1111_2222;
        vga_req = 1'b1; vga_addr = 12'h030;
        for (int i = 0; i < 4; i++) begin
            exp_ps2 = (i % 2 == 0);
            exp_rv  = (i == 2);
            #2;
            checks++;
            if ({ps2_gnt, vga_gnt, mem_wren, cpu_stall} !== {exp_ps2, ~exp_ps2, exp_ps2, 1'b0}
                || mem_addr !== (exp_ps2 ? 12'h020 : 12'h030)) begin
                errors++;
                $display("FAIL rr_cycle%0d: ps2/vga/wren/stall = %b addr %h, expected %b addr %h", i,
                         {ps2_gnt, vga_gnt, mem_wren, cpu_stall}, mem_addr,
                         {exp_ps2, ~exp_ps2, exp_ps2, 1'b0}, exp_ps2 ? 12'h020 : 12'h030);
            end
            checks++;
            if (vga_rvalid !== exp_rv || (exp_rv && vga_rdata !== 32'hCAFE_F00D)) begin
                errors++;
                $display("FAIL rr_rvalid%0d: rvalid %b data %h, expected %b cafef00d", i,
                         vga_rvalid, vga_rdata, exp_rv);
            end
            tick();
        end
        idle_all();
        #2;
        checks++;
        if (vga_rvalid !== 1'b1 || dmem[12'h020] !== 32'h1111_2222) begin
            errors++;
            $display("FAIL rr_final: vga_rvalid %b dmem[020] %h, expected 1 11112222",
                     vga_rvalid, dmem[12'h020]);
        end
        tick();
    endtask

    task automatic test_starve_vga;
        logic exp_v;
        do_reset();
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h040;
        vga_req = 1'b1; vga_addr = 12'h030;
        for (int c = 1; c <= 18; c++) begin
            exp_v = (c == 9 || c == 18);
            #2;
            checks++;
            if ({vga_gnt, cpu_stall, ps2_gnt} !== {exp_v, exp_v, 1'b0}) begin
                errors++;
                $display("FAIL starve_vga_cycle%0d: vga_gnt/stall/ps2 = %b, expected %b", c,
                         {vga_gnt, cpu_stall, ps2_gnt}, {exp_v, exp_v, 1'b0});
            end
            tick();
        end
        idle_all();
        tick();
    endtask

    task automatic test_starve_both;
        logic [2:0] exp;
        do_reset();
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h040;
        ps2_req = 1'b1; ps2_addr = 12'h050; ps2_wdata = 32'h5555_AAAA;
        vga_req = 1'b1; vga_addr = 12'h030;
        for (int c = 1; c <= 12; c++) begin
            // {ps2_gnt, vga_gnt, cpu_stall}
            if (c == 9)       exp = 3'b101;
            else if (c == 10) exp = 3'b011;
            else              exp = 3'b000;
            #2;
            checks++;
            if ({ps2_gnt, vga_gnt, cpu_stall} !== exp) begin
                errors++;
                $display("FAIL starve_both_cycle%0d: ps2/vga/stall = %b, expected %b", c,
                         {ps2_gnt, vga_gnt, cpu_stall}, exp);
            end
            tick();
        end
        idle_all();
        tick();
    endtask

    task automatic test_reset_in_flight;
        int first;
        do_reset();
        vga_req = 1'b1; vga_addr = 12'h030;
        #2;
        checks++;
        if (vga_gnt !== 1'b1) begin
            errors++;
            $display("FAIL inflight_gnt: vga_gnt %b, expected 1", vga_gnt);
        end
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        vga_req = 1'b0;
        tick();
        #2;
        checks++;
        if (vga_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL inflight_rvalid: vga_rvalid %b, expected 0", vga_rvalid);
        end
        tick();
        // Build up a partial VGA count, pulse reset mid-cycle, then measure time to next grant.
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h040;
        vga_req = 1'b1; vga_addr = 12'h030;
        for (int c = 0; c < 4; c++) tick();
        #2;
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        tick();
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            #2;
            if (first == 0 && vga_gnt === 1'b1) first = k;
            tick();
        end
        checks++;
        if (first !== 8) begin
            errors++;
            $display("FAIL counters_cleared: vga granted %0d cycles after pulse (0 = never), expected 8",
                     first);
        end
        idle_all();
        tick();
    endtask

    initial begin
        idle_all();
        resetn = 1'b0;
        #1;
        test_reset();
        test_cpu_rw();
        test_round_robin();
        test_starve_vga();
        test_starve_both();
        test_reset_in_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
